// File: rtl/sdram_dl_bridge.sv
// sdram_dl_bridge: buffers ioctl ROM download bytes and writes them to one SDRAM toggle req/ack port
//
// Ports:
//   clk, reset_n                     system clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout  hps_io download stream
//   ioctl_wait                       stall request to hps_io (FIFO nearly full)
//   port_req/ack/we/a/ds/d           SDRAM write port, toggle handshake
//   dl_done                          1-cycle pulse once download ended and all writes acknowledged
//
// Optional build macro SDRAM_DL_PACK_EN: merges an even/odd byte pair at the FIFO head
// into a single 16-bit write.
module sdram_dl_bridge #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  DL_INDEX   = 8'd0,
    parameter logic [24:0] SWZ_BASE   = 25'h10000,
    parameter logic [24:0] SWZ_END    = 25'h18000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port_req,
    input  logic        port_ack,
    output logic        port_we,
    output logic [22:0] port_a,
    output logic [1:0]  port_ds,
    output logic [15:0] port_d,
    output logic        dl_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [24:0]   mem_a [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp, rp, h;
    logic [AW:0]   count, count_nx, avail;
    logic [0:0]    state;
    logic [1:0]    n_fly, pop_n;
    logic          ovf, dl_prev, dl_end, dl_act, full, pop, push, issue, pack, drained;
    logic [24:0]   r, ra;
    logic [1:0]    ds_nx;
    logic [15:0]   d_nx;
`ifdef SDRAM_DL_PACK_EN
    logic [AW-1:0] h1;
    logic [24:0]   rb;
`endif

    always_comb begin
        dl_act   = ioctl_download & (ioctl_index == DL_INDEX);
        full     = count == (AW+1)'(FIFO_DEPTH);
        pop      = (state == S_WAIT) & (port_ack == port_req);
        pop_n    = pop ? n_fly : 2'd0;
        // a pop frees a slot in the same cycle, so a full FIFO may still accept
        push     = ioctl_wr & dl_act & (!full | pop);
        count_nx = count + (AW+1)'(push) - (AW+1)'(pop_n);
        avail    = count - (AW+1)'(pop_n);
        h        = rp + AW'(pop_n);
        ra       = mem_a[h];
        issue    = (avail != '0) & ((state == S_IDLE) | pop);
        drained  = dl_end & (count == '0) & (state == S_IDLE);
        // 16-bit region: address bit 14 selects the byte lane
        r = (ioctl_addr >= SWZ_BASE && ioctl_addr < SWZ_END)
            ? {ioctl_addr[24:15], ioctl_addr[13:0], ioctl_addr[14]} : ioctl_addr;
`ifdef SDRAM_DL_PACK_EN
        h1    = h + AW'(1);
        rb    = mem_a[h1];
        pack  = (avail >= (AW+1)'(2)) & !ra[0] & rb[0] & (ra[24:1] == rb[24:1]);
        ds_nx = pack ? 2'b11 : {ra[0], ~ra[0]};
        d_nx  = pack ? {mem_d[h1], mem_d[h]} : {2{mem_d[h]}};
`else
        pack  = 1'b0;
        ds_nx = {ra[0], ~ra[0]};
        d_nx  = {2{mem_d[h]}};
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wp] <= r;
            mem_d[wp] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            state      <= S_IDLE;
            n_fly      <= 2'd0;
            ovf        <= 1'b0;
            dl_prev    <= 1'b0;
            dl_end     <= 1'b0;
            ioctl_wait <= 1'b0;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            dl_done    <= 1'b0;
        end else begin
            wp         <= push ? wp + AW'(1) : wp;
            rp         <= h;
            count      <= count_nx;
            ioctl_wait <= count_nx >= (AW+1)'(FIFO_DEPTH - 1);
            ovf        <= ovf | (ioctl_wr & dl_act & !push);
            if (issue) begin
                port_a   <= ra[23:1];
                port_ds  <= ds_nx;
                port_d   <= d_nx;
                port_we  <= 1'b1;
                port_req <= ~port_req;
                n_fly    <= pack ? 2'd2 : 2'd1;
                state    <= S_WAIT;
            end else if (pop) begin
                port_we <= 1'b0;
                state   <= S_IDLE;
            end
            dl_prev <= dl_act;
            dl_done <= drained;
            dl_end  <= (dl_act & !dl_prev) ? 1'b0 : (!dl_act & dl_prev) ? 1'b1 : drained ? 1'b0 : dl_end;
        end
    end
endmodule
